matrix_key_scanner: RTL and testbench
=====================================

MATRIX_KEY_SCANNER -- requirements
Module: matrix_key_scanner

Interface
REQ-001 SHALL provide parameter ROWS, default 4, number of driven rows (2..8).
REQ-002 SHALL provide parameter COLS, default 4, number of sensed columns (2..8).
REQ-003 SHALL provide parameter SCAN_DIV, default 12000, clocks per row slot (>= COLS+4).
REQ-004 SHALL provide parameter DEBOUNCE_SCANS, default 3, consecutive agreeing samples needed to change key state (1..15).
REQ-005 SHALL provide parameter FIFO_DEPTH, default 8, event queue depth (power of two, >= 2).
REQ-006 SHALL provide clk  input  1  single system clock.
REQ-007 SHALL provide rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL provide row  output  ROWS  active-low row drive, at most one bit low.
REQ-009 SHALL provide col  input  COLS  active-low column sense (0 = pressed), asynchronous.
REQ-010 SHALL provide key_state  output  ROWS*COLS  debounced level per key, bit index r*COLS+c.
REQ-011 SHALL provide evt_valid / evt_ready  output / input  1 / 1  event handshake.
REQ-012 SHALL provide evt_code  output  KW=$clog2(ROWS*COLS)  key index of head event.
REQ-013 SHALL provide evt_press / evt_repeat  output  1 / 1  1 = press (0 = release); repeat-generated flag.
REQ-014 SHALL provide ovf / ovf_clr  output / input  1 / 1  sticky drop flag; synchronous clear.

Function
REQ-015 Row slots SHALL cycle 0,1,...,ROWS-1,0; each slot drives only its row low for exactly SCAN_DIV clocks.
REQ-016 col SHALL pass a 2-flop synchronizer; the row sample SHALL be latched on the last clock of each slot.
REQ-017 After a sample, one key per clock (c = 0..COLS-1) SHALL be evaluated over the next COLS clocks of the following slot.
REQ-018 Per key: sample == stable state SHALL clear its counter; otherwise counter increments and at DEBOUNCE_SCANS the state flips and the counter clears.
REQ-019 Each state flip SHALL push one event {code, press, repeat=0}; at most one push per clock.
REQ-020 evt_valid SHALL be high iff FIFO non-empty; pop SHALL occur on evt_valid & evt_ready; head fields stable while valid & !ready.
REQ-021 Push with FIFO full and no pop SHALL drop the event and set ovf; push and pop in the same clock when full SHALL both succeed.
REQ-022 ovf_clr SHALL clear ovf next clock unless a drop occurs that same clock (drop wins).
REQ-023 Event order SHALL equal evaluation order; FIFO pointers SHALL wrap modulo FIFO_DEPTH with an extra wrap bit for full/empty.

Reset
REQ-024 rst_n low SHALL asynchronously force row all-ones, key_state 0, counters 0, FIFO empty, evt_valid 0, evt_code 0, evt_press 0, evt_repeat 0, ovf 0.
REQ-025 First row-0 slot SHALL begin on the first clock after rst_n deasserts; reset mid-scan SHALL discard all pending events.

Configuration
REQ-026 With MKS_AUTOREPEAT_EN defined: the most recently pressed key, while still held, SHALL push press events with evt_repeat=1 after REPEAT_DELAY (default 32) full frames, then every REPEAT_PERIOD (default 8) frames; another press or its release SHALL restart/stop repeat.
REQ-027 Without MKS_AUTOREPEAT_EN: no repeat logic, REPEAT_* parameters ignored, evt_repeat tied 0.

Structure
REQ-028 Shared package mks_pkg SHALL hold the event struct (code, press, repeat) field widths and default parameter constants.
REQ-029 The event FIFO SHALL be a sub-module mks_event_fifo (synchronous, parametrised width/depth, full/empty/push/pop).

Verification (ROWS=4, COLS=4, SCAN_DIV=8, DEBOUNCE_SCANS=3, FIFO_DEPTH=4)
REQ-030 Reset release, no keys -> row sequence 1110,1101,1011,0111 each 8 clocks, evt_valid stays 0.
REQ-031 Hold col=1101 during row 1110 slots for 3 frames, evt_ready=1 -> one event code 1 press=1, key_state[1]=1; release 3 frames -> code 1 press=0.
REQ-032 col=1101 glitch for 2 frames only -> no event, key_state unchanged.
REQ-033 evt_ready=0, 6 distinct debounced presses -> first 4 retained in order, ovf=1; ovf_clr pulse -> ovf=0.
REQ-034 FIFO full, evt_ready=1 in the clock of a new push -> no drop, ovf stays 0, count stays 4.
REQ-035 MKS_AUTOREPEAT_EN, key 5 held 48 frames -> initial press, then repeat=1 events at frames 32 and 40 after the press.

Source files
------------

// File: rtl/mks_pkg.sv
// Shared types and default constants for the matrix key scanner.
// The auto-repeat defaults exist only when MKS_AUTOREPEAT_EN is defined.
package mks_pkg;

    localparam int MKS_ROWS_DEF       = 4;
    localparam int MKS_COLS_DEF       = 4;
    localparam int MKS_SCAN_DIV_DEF   = 12000;
    localparam int MKS_DEBOUNCE_DEF   = 3;
    localparam int MKS_FIFO_DEPTH_DEF = 8;
    localparam int MKS_DEB_CNT_W      = 4;

`ifdef MKS_AUTOREPEAT_EN
    localparam int MKS_REPEAT_DELAY_DEF  = 32;
    localparam int MKS_REPEAT_PERIOD_DEF = 8;
`endif

    // Event flags carried beside the key code: press (1) / release (0) and repeat origin.
    typedef struct packed {
        logic press;
        logic rpt;
    } mks_flags_t;

    function automatic int mks_code_w(input int rows, input int cols);
        return $clog2(rows * cols);
    endfunction

endpackage

// File: rtl/matrix_key_scanner_if.sv
// Key event handshake and overflow status between the scanner and its consumer.
interface matrix_key_scanner_if #(
    parameter int KW = 4
);
    logic          evt_valid;
    logic          evt_ready;
    logic [KW-1:0] evt_code;
    logic          evt_press;
    logic          evt_repeat;
    logic          ovf;
    logic          ovf_clr;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_press,
        output evt_repeat,
        output ovf,
        input  evt_ready,
        input  ovf_clr
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_press,
        input  evt_repeat,
        input  ovf,
        output evt_ready,
        output ovf_clr
    );
endinterface

// File: rtl/mks_event_fifo.sv
// Synchronous event FIFO; pointers carry an extra wrap bit to separate full from empty.
module mks_event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same clock frees the slot the push lands in.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end
endmodule

// File: rtl/matrix_key_scanner.sv
// Row-strobed key matrix scanner with per-key debounce and a queued event stream.
// Optional auto-repeat of the last pressed key is enabled by defining MKS_AUTOREPEAT_EN.
//
// state     | meaning
// ST_START  | out of reset, rows released, first row-0 slot starts next clock
// ST_SCAN   | rows strobed in turn, one SCAN_DIV-clock slot each
module matrix_key_scanner
    import mks_pkg::*;
#(
    parameter int ROWS           = MKS_ROWS_DEF,
    parameter int COLS           = MKS_COLS_DEF,
    parameter int SCAN_DIV       = MKS_SCAN_DIV_DEF,
    parameter int DEBOUNCE_SCANS = MKS_DEBOUNCE_DEF,
    parameter int FIFO_DEPTH     = MKS_FIFO_DEPTH_DEF
`ifdef MKS_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY   = MKS_REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD  = MKS_REPEAT_PERIOD_DEF
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [ROWS-1:0]        row,
    input  logic [COLS-1:0]        col,
    output logic [ROWS*COLS-1:0]   key_state,
    matrix_key_scanner_if.master   evt_if
);
    localparam int NKEYS = ROWS * COLS;
    localparam int KW    = mks_code_w(ROWS, COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int DW    = $clog2(SCAN_DIV);
`ifdef MKS_AUTOREPEAT_EN
    localparam int EW    = KW + $bits(mks_flags_t);
`else
    localparam int EW    = KW + 1;
`endif

    localparam logic [0:0] ST_START = 1'b0;
    localparam logic [0:0] ST_SCAN  = 1'b1;

    logic [0:0]    state;
    logic [DW-1:0] div_cnt;
    logic [RW-1:0] row_idx;
    logic [RW-1:0] next_row_idx;
    logic          slot_end;

    assign slot_end     = (state == ST_SCAN) && (div_cnt == '0);
    assign next_row_idx = (row_idx == RW'(ROWS-1)) ? '0 : row_idx + RW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_START;
            div_cnt <= '0;
            row_idx <= '0;
            row     <= '1;
        end else begin
            case (state)
                ST_START: begin
                    state   <= ST_SCAN;
                    div_cnt <= DW'(SCAN_DIV-1);
                    row_idx <= '0;
                    row     <= ~ROWS'(1);
                end
                default: begin
                    if (div_cnt == '0) begin
                        div_cnt <= DW'(SCAN_DIV-1);
                        row_idx <= next_row_idx;
                        row     <= ~(ROWS'(1) << next_row_idx);
                    end else begin
                        div_cnt <= div_cnt - DW'(1);
                    end
                end
            endcase
        end
    end

    // Columns idle high, so the synchronizer resets to "nothing pressed".
    logic [COLS-1:0] col_s1;
    logic [COLS-1:0] col_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1 <= '1;
            col_s2 <= '1;
        end else begin
            col_s1 <= col;
            col_s2 <= col_s1;
        end
    end

    logic [COLS-1:0] smp_col;
    logic [RW-1:0]   smp_row;
    logic            eval_busy;
    logic [CW-1:0]   eval_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_col   <= '1;
            smp_row   <= '0;
            eval_busy <= 1'b0;
            eval_c    <= '0;
        end else if (slot_end) begin
            smp_col   <= col_s2;
            smp_row   <= row_idx;
            eval_busy <= 1'b1;
            eval_c    <= '0;
        end else if (eval_busy) begin
            if (eval_c == CW'(COLS-1)) begin
                eval_busy <= 1'b0;
            end
            eval_c <= eval_c + CW'(1);
        end
    end

    logic [MKS_DEB_CNT_W-1:0] deb_cnt [NKEYS];
    logic [MKS_DEB_CNT_W-1:0] cnt_inc;
    logic [KW-1:0]            key_idx;
    logic                     sample_pressed;
    logic                     flip;

    assign key_idx = KW'(int'(smp_row) * COLS + int'(eval_c));

    always_comb begin
        sample_pressed = ~smp_col[eval_c];
        cnt_inc        = deb_cnt[key_idx] + MKS_DEB_CNT_W'(1);
        flip           = eval_busy && (sample_pressed != key_state[key_idx])
                         && (cnt_inc == MKS_DEB_CNT_W'(DEBOUNCE_SCANS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_state <= '0;
            for (int k = 0; k < NKEYS; k++) begin
                deb_cnt[k] <= '0;
            end
        end else if (eval_busy) begin
            if (sample_pressed == key_state[key_idx]) begin
                deb_cnt[key_idx] <= '0;
            end else if (flip) begin
                deb_cnt[key_idx]   <= '0;
                key_state[key_idx] <= sample_pressed;
            end else begin
                deb_cnt[key_idx] <= cnt_inc;
            end
        end
    end

    logic          push;
    logic [EW-1:0] push_data;
    logic [EW-1:0] head;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_drop;
    logic          pop;

`ifdef MKS_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCW  = $clog2(RMAX + 1);

    logic           frame_end;
    logic           rpt_active;
    logic [KW-1:0]  rpt_key;
    logic [RCW-1:0] rpt_cnt;
    logic           rpt_fire;
    mks_flags_t     eval_flags;
    mks_flags_t     rpt_flags;
    mks_flags_t     head_flags;

    assign frame_end = slot_end && (row_idx == RW'(ROWS-1));
    // Loading the full delay skips the partial frame the press landed in.
    assign rpt_fire  = rpt_active && frame_end && (rpt_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_active <= 1'b0;
            rpt_key    <= '0;
            rpt_cnt    <= '0;
        end else if (flip && sample_pressed) begin
            rpt_active <= 1'b1;
            rpt_key    <= key_idx;
            rpt_cnt    <= RCW'(REPEAT_DELAY);
        end else if (flip && (key_idx == rpt_key)) begin
            rpt_active <= 1'b0;
        end else if (rpt_active && frame_end) begin
            rpt_cnt <= (rpt_cnt == '0) ? RCW'(REPEAT_PERIOD-1) : rpt_cnt - RCW'(1);
        end
    end

    // Frame ends fall outside the evaluation window, so the two sources never collide.
    assign eval_flags = '{press: sample_pressed, rpt: 1'b0};
    assign rpt_flags  = '{press: 1'b1, rpt: 1'b1};
    assign push       = flip || rpt_fire;
    assign push_data  = flip ? {key_idx, eval_flags} : {rpt_key, rpt_flags};

    assign head_flags        = head[1:0];
    assign evt_if.evt_code   = head[EW-1:2];
    assign evt_if.evt_press  = head_flags.press;
    assign evt_if.evt_repeat = head_flags.rpt;
`else
    assign push              = flip;
    assign push_data         = {key_idx, sample_pressed};
    assign evt_if.evt_code   = head[EW-1:1];
    assign evt_if.evt_press  = head[0];
    assign evt_if.evt_repeat = 1'b0;
`endif

    assign pop              = !fifo_empty && evt_if.evt_ready;
    assign evt_if.evt_valid = !fifo_empty;

    mks_event_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (push_data),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (fifo_drop) begin
            ovf_q <= 1'b1;
        end else if (evt_if.ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign evt_if.ovf = ovf_q;

    // Full status is implied by the pointers; kept visible for debug probing.
    logic unused_full;
    assign unused_full = fifo_full;
endmodule

// File: tb/tb_matrix_key_scanner.sv
// Scoreboard bench for matrix_key_scanner: stimulus queues expected events, a monitor checks pops.
`timescale 1ns/1ps
module tb_matrix_key_scanner;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int SDIV  = 8;
    localparam int DEB   = 3;
    localparam int DEPTH = 4;
    localparam int KW    = 4;
    localparam int FRAME = ROWS * SDIV;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [ROWS-1:0]      row;
    logic [COLS-1:0]      col;
    logic [ROWS*COLS-1:0] key_state;
    logic [ROWS*COLS-1:0] keys_down = '0;

    matrix_key_scanner_if #(.KW(KW)) evt_if();

    matrix_key_scanner #(
        .ROWS           (ROWS),
        .COLS           (COLS),
        .SCAN_DIV       (SDIV),
        .DEBOUNCE_SCANS (DEB),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .key_state (key_state),
        .evt_if    (evt_if)
    );

    always #5 clk = ~clk;

    // Keyboard model: a held key pulls its column low while its row is driven low.
    always_comb begin
        col = '1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (!row[r] && keys_down[r*COLS+c]) col[c] = 1'b0;
            end
        end
    end

    typedef struct {
        logic [KW-1:0] code;
        logic          press;
        logic          rpt;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic expect_ev(input int code, input logic press, input logic rpt);
        ev_t e;
        e.code  = KW'(code);
        e.press = press;
        e.rpt   = rpt;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_slot(input logic [ROWS-1:0] target);
        logic [ROWS-1:0] prev;
        bit              hit;
        hit  = 1'b0;
        prev = row;
        for (int i = 0; i < 4 * FRAME && !hit; i++) begin
            @(posedge clk);
            #1;
            if (row == target && prev != target) hit = 1'b1;
            prev = row;
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL wait_slot: row stayed %b, required entry into %b", row, target);
        end
    endtask

    // Monitor: every accepted handshake must match the head of the expected queue.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (rst_n && evt_if.evt_valid && evt_if.evt_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got code=%0d press=%0b rpt=%0b, required no event",
                             evt_if.evt_code, evt_if.evt_press, evt_if.evt_repeat);
                end else begin
                    e = exp_q.pop_front();
                    if (evt_if.evt_code !== e.code || evt_if.evt_press !== e.press ||
                        evt_if.evt_repeat !== e.rpt) begin
                        errors++;
                        $display("FAIL event: got code=%0d press=%0b rpt=%0b, required code=%0d press=%0b rpt=%0b",
                                 evt_if.evt_code, evt_if.evt_press, evt_if.evt_repeat,
                                 e.code, e.press, e.rpt);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ROWS-1:0] exp_row;
        bit              saw_valid;

        evt_if.evt_ready = 1'b0;
        evt_if.ovf_clr   = 1'b0;
        rst_n            = 1'b0;
        wait_clks(3);

        check("rst_row",       row,               4'b1111);
        check("rst_key_state", key_state,         16'h0000);
        check("rst_valid",     evt_if.evt_valid,  1'b0);
        check("rst_code",      evt_if.evt_code,   4'h0);
        check("rst_press",     evt_if.evt_press,  1'b0);
        check("rst_repeat",    evt_if.evt_repeat, 1'b0);
        check("rst_ovf",       evt_if.ovf,        1'b0);

        // Idle scan: row 0 on the first clock after release, SDIV clocks per slot.
        @(negedge clk);
        rst_n     = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(posedge clk);
            #1;
            exp_row = '1;
            exp_row[(i / SDIV) % ROWS] = 1'b0;
            check("row_seq", row, exp_row);
            if (evt_if.evt_valid) saw_valid = 1'b1;
        end
        check("idle_no_valid", saw_valid, 1'b0);

        // Debounced press and release of key 1 (row 0, col 1).
        evt_if.evt_ready = 1'b1;
        wait_slot(4'b1110);
        keys_down[1] = 1'b1;
        expect_ev(1, 1'b1, 1'b0);
        wait_clks(4 * FRAME);
        check("press_state", key_state, 16'h0002);
        keys_down[1] = 1'b0;
        expect_ev(1, 1'b0, 1'b0);
        wait_clks(4 * FRAME);
        check("release_state", key_state, 16'h0000);
        check("queue_after_key1", exp_q.size(), 0);

        // Two-sample glitch must not change state.
        wait_slot(4'b1110);
        keys_down[1] = 1'b1;
        wait_clks(2 * FRAME);
        keys_down[1] = 1'b0;
        wait_clks(4 * FRAME);
        check("glitch_state", key_state, 16'h0000);
        check("glitch_valid", evt_if.evt_valid, 1'b0);

        // Overflow: six presses with no consumer, only the first four survive.
        evt_if.evt_ready = 1'b0;
        wait_slot(4'b1110);
        keys_down[5:0] = 6'h3f;
        for (int k = 0; k < 4; k++) expect_ev(k, 1'b1, 1'b0);
        wait_clks(4 * FRAME);
        check("ovf_set",    evt_if.ovf,       1'b1);
        check("full_valid", evt_if.evt_valid, 1'b1);
        check("six_state",  key_state,        16'h003f);
        evt_if.ovf_clr = 1'b1;
        wait_clks(1);
        evt_if.ovf_clr = 1'b0;
        check("ovf_clr", evt_if.ovf, 1'b0);
        evt_if.evt_ready = 1'b1;
        wait_clks(8);
        check("drain_four", exp_q.size(), 0);
        wait_slot(4'b1110);
        keys_down = '0;
        for (int k = 0; k < 6; k++) expect_ev(k, 1'b0, 1'b0);
        wait_clks(4 * FRAME);
        check("release_six_ovf",   evt_if.ovf,    1'b0);
        check("release_six_state", key_state,     16'h0000);
        check("release_six_queue", exp_q.size(),  0);

        // Full FIFO with a pop in the same clock as key 4's push: nothing is dropped.
        evt_if.evt_ready = 1'b0;
        wait_slot(4'b1110);
        keys_down[4:0] = 5'h1f;
        for (int k = 0; k < 5; k++) expect_ev(k, 1'b1, 1'b0);
        repeat (3) wait_slot(4'b1011);
        evt_if.evt_ready = 1'b1;
        wait_clks(1);
        evt_if.evt_ready = 1'b0;
        check("full_pop_ovf",   evt_if.ovf,       1'b0);
        check("full_pop_valid", evt_if.evt_valid, 1'b1);
        check("five_state",     key_state,        16'h001f);
        evt_if.evt_ready = 1'b1;
        wait_clks(8);
        check("full_pop_queue", exp_q.size(), 0);
        check("full_pop_ovf2",  evt_if.ovf,   1'b0);
        wait_slot(4'b1110);
        keys_down = '0;
        for (int k = 0; k < 5; k++) expect_ev(k, 1'b0, 1'b0);
        wait_clks(4 * FRAME);

`ifdef MKS_AUTOREPEAT_EN
        // Key 5 held: initial press, then repeats 32 and 40 frames later.
        wait_slot(4'b1110);
        keys_down[5] = 1'b1;
        expect_ev(5, 1'b1, 1'b0);
        expect_ev(5, 1'b1, 1'b1);
        expect_ev(5, 1'b1, 1'b1);
        wait_clks(48 * FRAME);
        check("repeat_queue", exp_q.size(), 0);
        keys_down[5] = 1'b0;
        expect_ev(5, 1'b0, 1'b0);
        wait_clks(4 * FRAME);
`endif

        check("final_queue", exp_q.size(), 0);
        check("final_ovf",   evt_if.ovf,   1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
